// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {HZ_RUN, HZ_DISCARD} hz_state_t;

    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam logic [DEFAULT_REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush generation for the 5-stage pipeline: load-use, branch redirect,
// fetch wait, data-memory wait and wrong-path fetch discard, plus perf counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    input  logic                  cnt_clear,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic [WIDTH-1:0]      stall_cycles,
    output logic [WIDTH-1:0]      flush_events
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      load_use;
    logic      redirect;

    assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        redirect     = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            pc_stall     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dmem_busy) begin
            // Full freeze; a branch in EX stays put and is taken once memory completes.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
            state_d     = imem_ready ? HZ_RUN : HZ_DISCARD;
        end else begin
            if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            if (state_q == HZ_DISCARD) begin
                // The word arriving now belongs to the abandoned path.
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                if (imem_ready) begin
                    state_d = HZ_RUN;
                end
            end else if (!imem_ready && !load_use) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clear),
        .inc   (pc_stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clear),
        .inc   (redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table plus randomized run vs. a rule model.
module tb_hazard_unit;

    localparam int W   = 4;
    localparam int SAT = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [4:0]   id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic         id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0;
    logic         ex_branch_taken = 0, imem_ready = 1, dmem_busy = 0, cnt_clear = 0;
    logic         pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic         if_id_flush, id_ex_flush, mem_wb_flush;
    logic [W-1:0] stall_cycles, flush_events;

    hazard_unit #(.WIDTH(W), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    // ctl bit order: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush}
    logic [6:0] got_ctl;
    assign got_ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, mem_wb_flush};

    typedef struct {
        logic       rst, busy, br, imem, clr, mrd;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2;
        logic [6:0] ctl;
        int         sc, fc;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    bit m_disc = 0;
    int m_sc = 0, m_fc = 0;

    function automatic vec_t mk(bit r, bit busy, bit br, bit imem, bit clr, bit mrd,
                                int rd, int rs1, bit u1, int rs2, bit u2,
                                logic [6:0] ctl, int sc, int fc);
        vec_t v;
        v.rst = r; v.busy = busy; v.br = br; v.imem = imem; v.clr = clr; v.mrd = mrd;
        v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.ctl = ctl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic vec_t idle(logic [6:0] ctl, int sc, int fc);
        return mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ctl, sc, fc);
    endfunction

    function automatic logic [6:0] model_ctl(vec_t v, bit disc);
        bit lu;
        lu = v.mrd && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (!v.rst)     return 7'b1000111;
        if (v.busy)     return 7'b1111001;
        if (v.br)       return 7'b0000110;
        if (disc)       return lu ? 7'b1100110 : 7'b1000100;
        if (lu)         return 7'b1100010;
        if (!v.imem)    return 7'b1000100;
        return 7'b0000000;
    endfunction

    function automatic int sat_inc(int x);
        return (x >= SAT) ? SAT : x + 1;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // Called at a negedge: drive, check, advance model across the next posedge.
    task automatic step(vec_t v, bit use_tbl);
        logic [6:0] e;
        bit         acc;
        rst = v.rst; dmem_busy = v.busy; ex_branch_taken = v.br; imem_ready = v.imem;
        cnt_clear = v.clr; ex_mem_read = v.mrd; ex_rd = v.rd;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
        #1;
        if (!v.rst) begin
            m_disc = 0; m_sc = 0; m_fc = 0;
        end
        e = model_ctl(v, m_disc);
        chk("model_ctl", 32'(got_ctl), 32'(e));
        chk("model_stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("model_flush_events", 32'(flush_events), 32'(m_fc));
        if (use_tbl) begin
            chk("tbl_ctl", 32'(got_ctl), 32'(v.ctl));
            chk("tbl_stall_cycles", 32'(stall_cycles), 32'(v.sc));
            chk("tbl_flush_events", 32'(flush_events), 32'(v.fc));
        end
        @(posedge clk);
        if (v.rst) begin
            acc = !v.busy && v.br;
            if (acc)                         m_disc = !v.imem;
            else if (!v.busy && m_disc && v.imem) m_disc = 0;
            m_sc = v.clr ? 0 : (e[6] ? sat_inc(m_sc) : m_sc);
            m_fc = v.clr ? 0 : (acc ? sat_inc(m_fc) : m_fc);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t r;
        // reset state
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7'b1000111, 0, 0));
        tbl.push_back(idle(7'b0000000, 0, 0));
        // load-use via rs1, then x0 exclusion, then rs2 used / unused
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 5, 5, 1, 0, 0, 7'b1100010, 0, 0));
        tbl.push_back(idle(7'b0000000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 7'b0000000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 7, 0, 0, 7, 1, 7'b1100010, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 7, 0, 0, 7, 0, 7'b0000000, 2, 0));
        // branch with imem ready stays RUN
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 2, 0));
        tbl.push_back(idle(7'b0000000, 2, 1));
        // branch with imem not ready: DISCARD for three cycles
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 2, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 3, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 4, 2));
        tbl.push_back(idle(7'b0000000, 5, 2));
        // dmem_busy with held branch: freeze then single redirect
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b1111001, 5 + i, 2));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 8, 2));
        tbl.push_back(idle(7'b0000000, 8, 3));
        // fetch wait in RUN, load-use overrides it
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 8, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 3, 1, 0, 0, 7'b1100010, 9, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 10, 3));
        // clear wins over a stall increment
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b1000100, 11, 3));
        tbl.push_back(idle(7'b0000000, 0, 0));
        // stall counter saturation at 15
        for (int i = 0; i < 18; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, (i > SAT) ? SAT : i, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b1000100, SAT, 0));
        tbl.push_back(idle(7'b0000000, 0, 0));
        // branch while already discarding is counted again
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 0, 2));
        tbl.push_back(idle(7'b0000000, 1, 2));
        // load-use ORed into a discard cycle
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 1, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 9, 0, 0, 9, 1, 7'b1100110, 1, 3));
        tbl.push_back(idle(7'b0000000, 2, 3));

        @(negedge clk);
        foreach (tbl[i]) step(tbl[i], 1'b1);

        // asynchronous reset in the middle of a DISCARD cycle
        step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 2, 3), 1'b1);
        imem_ready = 0;
        #3 rst = 0;
        #1;
        chk("async_rst_ctl", 32'(got_ctl), 32'(7'b1000111));
        chk("async_rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("async_rst_flush_events", 32'(flush_events), 32'd0);
        m_disc = 0; m_sc = 0; m_fc = 0;
        @(negedge clk);
        step(idle(7'b0000000, 0, 0), 1'b1);

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            r = idle(7'b0, 0, 0);
            r.rst  = ($urandom_range(0, 49) != 0);
            r.busy = ($urandom_range(0, 5) == 0);
            r.br   = ($urandom_range(0, 4) == 0);
            r.imem = ($urandom_range(0, 2) != 0);
            r.clr  = ($urandom_range(0, 15) == 0);
            r.mrd  = ($urandom_range(0, 2) == 0);
            r.rd   = 5'($urandom_range(0, 3));
            r.rs1  = 5'($urandom_range(0, 3));
            r.rs2  = 5'($urandom_range(0, 3));
            r.u1   = 1'($urandom_range(0, 1));
            r.u2   = 1'($urandom_range(0, 1));
            step(r, 1'b0);
        end
        rst = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
